cpu_controller: RTL and testbench
=================================

# cpu_controller

Eight-phase instruction sequencer for the accumulator CPU. It steps a phase counter through fetch, decode and execute. From the current phase and the instruction-register opcode it drives the control strobes for:
- the program counter (ld_pc, inc_pc);
- the address mux (sel);
- memory (rd, wr);
- the instruction register (ld_ir);
- the accumulator (ld_ac);
- the data bus driver (data_e).

It sits between the instruction register/ALU zero flag and every datapath register.

## Interface
- OPC_WIDTH, 3, opcode width; the 8-entry opcode map below is fixed to this width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPC_WIDTH  instruction-register opcode field, valid from phase IDLE onward
- zero  in  1  accumulator-is-zero flag
- sel  out  1  address mux: 1 = PC, 0 = IR operand address
- rd  out  1  memory read enable
- wr  out  1  memory write enable
- ld_ir  out  1  instruction-register load
- ld_ac  out  1  accumulator load
- ld_pc  out  1  PC load (jump)
- inc_pc  out  1  PC increment
- data_e  out  1  accumulator-to-bus driver enable
- halt  out  1  sticky halted status

## Operation
- Opcode map: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD, AND, XOR or LDA.
- Phase counter, 3 bits, in this order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7).
  - The counter advances by 1 every clock and wraps 7→0.
  - While halted, the counter holds.
- Outputs are combinational decode of (phase, opcode, zero, halted) and are registered nowhere else. Each output is 0 unless listed:
  - sel=1 in phases 0–3.
  - rd=1 in phases 1–3; also in phases 5–7 when ALUOP.
  - ld_ir=1 in phases 2–3.
  - inc_pc=1 in OP_ADDR when opcode≠HLT; also in ALU_OP when SKZ and zero=1.
  - ld_pc=1 in ALU_OP and STORE when JMP.
  - ld_ac=1 in STORE when ALUOP.
  - data_e=1 in ALU_OP and STORE when STO.
  - wr=1 in STORE when STO.
- Halt handling:
  - In OP_ADDR with opcode=HLT, the sticky halted flag sets on the clock edge.
  - From the next cycle the phase freezes at OP_ADDR.
  - While halted, all strobes are forced 0 and halt=1.
  - Only rst_n clears halted.
- inc_pc and ld_pc are never asserted together. SKZ with zero=0 behaves as a NOP.

## Timing
- Reset (rst_n=0, asynchronous) forces phase=INST_ADDR and halted=0. Output values during and after reset:
  - sel=1.
  - All other outputs 0, including halt.
- After rst_n deasserts, the first rising edge moves the phase to INST_FETCH.
- Instruction latency: 8 clocks per instruction, fixed.
- The HLT instruction's OP_ADDR cycle already shows halt=0 and inc_pc=0. halt rises one clock later.
- Asserting rst_n low mid-instruction aborts immediately. The phase returns to 0 with no partial strobes after the reset edge.
- Opcode changes outside phases 3–7 have no effect on strobes, because no opcode-dependent output is active there.

## Configuration
- CTRL_SKZ_EN:
  - Defined: SKZ performs the extra inc_pc in ALU_OP when zero=1, as specified above.
  - Undefined: SKZ is decoded as a NOP and never generates the ALU_OP inc_pc, regardless of zero.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 clocks → sel=1, all other outputs 0, halt=0. Release → phase sequence 1,2,…,7,0 on successive edges.
- ADD (opcode=2), zero=0:
  - rd=1 in phases 1–3 and 5–7.
  - ld_ir=1 in phases 2–3.
  - inc_pc=1 only in phase 4.
  - ld_ac=1 only in phase 7.
  - wr=0 throughout.
- STO (opcode=6) → data_e=1 in phases 6–7, wr=1 in phase 7, rd=0 in phases 5–7, ld_ac=0.
- JMP (opcode=7) → inc_pc=1 in phase 4 and ld_pc=1 in phases 6–7; never inc_pc and ld_pc in the same cycle.
- SKZ (opcode=1):
  - zero=1 → inc_pc=1 in phases 4 and 6 with CTRL_SKZ_EN defined; phase 4 only without it.
  - zero=0 → phase 4 only in both builds.
- HLT (opcode=0):
  - phase 4 gives inc_pc=0.
  - Next edge: halt=1, all strobes 0, phase stuck at 4 for 20 clocks.
  - Async rst_n pulse → halt=0 and phase=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Eight-phase instruction sequencer for the accumulator CPU. A 3-bit phase
// counter steps through fetch (phases 0-3) and execute (phases 4-7). The
// datapath strobes are a combinational decode of phase, opcode, zero flag and
// the sticky halted flag.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   opcode  in   instruction-register opcode field (OPC_WIDTH bits)
//   zero    in   accumulator-is-zero flag
//   sel     out  address mux select (1 = PC, 0 = IR operand address)
//   rd      out  memory read enable
//   wr      out  memory write enable
//   ld_ir   out  instruction-register load
//   ld_ac   out  accumulator load
//   ld_pc   out  PC load (jump)
//   inc_pc  out  PC increment
//   data_e  out  accumulator-to-bus driver enable
//   halt    out  sticky halted status
//
// Configuration macro: CTRL_SKZ_EN
//   defined   : SKZ adds an inc_pc in ALU_OP when zero=1 (skip next instr)
//   undefined : SKZ is decoded as a NOP
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter int OPC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
    output logic                 sel,
    output logic                 rd,
    output logic                 wr,
    output logic                 ld_ir,
    output logic                 ld_ac,
    output logic                 ld_pc,
    output logic                 inc_pc,
    output logic                 data_e,
    output logic                 halt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [OPC_WIDTH-1:0] OPC_HLT = 3'd0;
    localparam logic [OPC_WIDTH-1:0] OPC_SKZ = 3'd1;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD = 3'd2;
    localparam logic [OPC_WIDTH-1:0] OPC_AND = 3'd3;
    localparam logic [OPC_WIDTH-1:0] OPC_XOR = 3'd4;
    localparam logic [OPC_WIDTH-1:0] OPC_LDA = 3'd5;
    localparam logic [OPC_WIDTH-1:0] OPC_STO = 3'd6;
    localparam logic [OPC_WIDTH-1:0] OPC_JMP = 3'd7;

    // The skip feature is folded in as a constant so zero stays a live input
    // in both builds.
`ifdef CTRL_SKZ_EN
    localparam logic SKZ_EN = 1'b1;
`else
    localparam logic SKZ_EN = 1'b0;
`endif

    phase_t r_phase;
    logic   r_halted;

    logic w_is_hlt;
    logic w_is_alu;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_skip;

    assign w_is_hlt = (opcode == OPC_HLT);
    assign w_is_alu = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                      (opcode == OPC_XOR) || (opcode == OPC_LDA);
    assign w_is_sto = (opcode == OPC_STO);
    assign w_is_jmp = (opcode == OPC_JMP);
    assign w_skip   = SKZ_EN && (opcode == OPC_SKZ) && zero;

    assign halt = r_halted;

    // Phase counter and sticky halt flag; a halting instruction parks at OP_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_phase  <= r_phase;
            r_halted <= 1'b1;
        end else if ((r_phase == OP_ADDR) && w_is_hlt) begin
            r_phase  <= r_phase;
            r_halted <= 1'b1;
        end else begin
            r_phase  <= phase_t'(r_phase + 3'd1);
            r_halted <= 1'b0;
        end
    end

    // Strobe decode from phase and opcode; everything is forced low when halted.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        if (r_halted) begin
            sel = 1'b0;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    // HLT does not advance the PC; halt rises on this edge.
                    inc_pc = !w_is_hlt;
                end
                OP_FETCH: begin
                    rd = w_is_alu;
                end
                ALU_OP: begin
                    rd     = w_is_alu;
                    inc_pc = w_skip;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                STORE: begin
                    rd     = w_is_alu;
                    ld_ac  = w_is_alu;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                    wr     = w_is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Randomized scoreboard bench for cpu_controller. A stimulus process drives
// opcode/zero each cycle, advances a behavioural phase model and queues the
// expected strobe vector; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

    // Vector order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
    typedef logic [8:0] vec_t;
    typedef struct {
        vec_t       v;
        int         ph;
        logic [2:0] op;
    } item_t;

    item_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_phase  = 0;
    bit    m_halted = 1'b0;

`ifdef CTRL_SKZ_EN
    localparam bit SKZ_ON = 1'b1;
`else
    localparam bit SKZ_ON = 1'b0;
`endif

    localparam vec_t RESET_VEC = 9'b100000000;

    cpu_controller #(.OPC_WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    function automatic vec_t actual();
        return {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
    endfunction

    // Reference: what each instruction class does in each phase.
    function automatic vec_t model(int ph, bit hlt, logic [2:0] op, logic z);
        bit is_alu, fetch, e_sel, e_rd, e_wr, e_ir, e_ac, e_lpc, e_inc, e_de;
        if (hlt) return 9'b000000001;
        is_alu = (op >= 3'd2) && (op <= 3'd5);
        fetch  = (ph < 4);
        e_sel  = fetch;
        e_ir   = (ph == 2) || (ph == 3);
        e_rd   = (fetch && ph != 0) || (ph >= 5 && is_alu);
        e_ac   = (ph == 7) && is_alu;
        e_wr   = (ph == 7) && (op == 3'd6);
        e_de   = (ph >= 6) && (op == 3'd6);
        e_lpc  = (ph >= 6) && (op == 3'd7);
        e_inc  = ((ph == 4) && (op != 3'd0)) ||
                 ((ph == 6) && SKZ_ON && (op == 3'd1) && z);
        return {e_sel, e_rd, e_wr, e_ir, e_ac, e_lpc, e_inc, e_de, 1'b0};
    endfunction

    task automatic check(string name, vec_t act, vec_t exp_v, int ph, logic [2:0] op);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s phase=%0d op=%0d: got %b expected %b (sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt)",
                     name, ph, op, act, exp_v);
        end
    endtask

    // One clock of stimulus: drive inputs, queue the expectation, advance model.
    task automatic step(logic [2:0] op, logic z);
        item_t it;
        @(negedge clk);
        // Before IDLE the opcode is don't-care, so feed garbage there.
        opcode = (m_phase < 3 && !m_halted) ? 3'($urandom) : op;
        zero   = (m_phase == 6) ? z : 1'($urandom);
        it.v   = model(m_phase, m_halted, opcode, zero);
        it.ph  = m_phase;
        it.op  = opcode;
        exp_q.push_back(it);
        if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", actual(), RESET_VEC, 0, opcode);
        @(posedge clk);
        #3;
        check("reset_hold", actual(), RESET_VEC, 0, opcode);
        rst_n    = 1'b1;
        m_phase  = 0;
        m_halted = 1'b0;
    endtask

    task automatic run_instr(logic [2:0] op, logic z);
        for (int i = 0; i < 8; i++) step(op, z);
        if (op == 3'd0) begin
            for (int i = 0; i < 20; i++) step(op, z);
            reset_pulse();
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobes", actual(), e.v, e.ph, e.op);
                n_checks++;
                if (inc_pc && ld_pc) begin
                    n_errors++;
                    $display("FAIL pc_exclusive phase=%0d op=%0d: got inc_pc=1 ld_pc=1 expected not both",
                             e.ph, e.op);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [2:0] op;
        rst_n  = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_state", actual(), RESET_VEC, 0, opcode);
        end
        #2;
        rst_n = 1'b1;
        m_phase  = 0;
        m_halted = 1'b0;

        // Directed pass over each instruction class.
        run_instr(3'd2, 1'b0);  // ADD
        run_instr(3'd6, 1'b0);  // STO
        run_instr(3'd7, 1'b0);  // JMP
        run_instr(3'd1, 1'b1);  // SKZ, zero=1
        run_instr(3'd1, 1'b0);  // SKZ, zero=0
        run_instr(3'd3, 1'b1);  // AND
        run_instr(3'd4, 1'b0);  // XOR
        run_instr(3'd5, 1'b1);  // LDA
        run_instr(3'd0, 1'b0);  // HLT, then reset recovery

        // Randomized instruction stream with occasional halts.
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            run_instr(op, 1'($urandom));
        end
        run_instr(3'd2, 1'b0);

        repeat (2) @(negedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
